fm_freq_decimator: RTL and testbench
====================================

Name: fm_freq_decimator

Overview:
- Sits directly downstream of the CORDIC vectoring / phase-difference stage in the FM demodulation chain.
- Consumes the signed 16-bit instantaneous-frequency stream (inst_freq plus its valid strobe) and discards the first SKIP samples after reset, while the upstream phase-difference pipeline is still priming.
- Boxcar-averages each block of DECIM accepted samples and decimates by DECIM.
- Delivers results through a 2-entry output FIFO with a valid/ready handshake toward the audio back end, plus a sticky overflow flag.

Parameters:
- DECIM, 8: decimation ratio and averaging length; must be a power of two, 2..256.
- LOG2_DECIM, 3: log2(DECIM); must match DECIM.
- SKIP, 2: number of initial valid samples discarded after reset; 0 allowed.
- IN_W, 16: input/output sample width, signed.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- freq_i, input, IN_W: signed instantaneous-frequency sample from the CORDIC stage.
- valid_i, input, 1: freq_i is valid this cycle. There is no backpressure upstream; every valid_i cycle is a sample.
- freq_o, output, IN_W: signed decimated average, taken from the FIFO head.
- valid_o, output, 1: FIFO is non-empty; freq_o is valid.
- ready_i, input, 1: downstream accepts freq_o. A pop occurs when valid_o and ready_i are both high.
- overflow_o, output, 1: sticky; a result was dropped because the FIFO was full.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: freq_o=0, valid_o=0, overflow_o=0, FIFO empty, accumulator=0, sample counter=0, state=SKIPPING (or ACCUM if SKIP=0), skip counter=0.
- The FSM has two states.
  - SKIPPING: each valid_i increments the skip counter. The sample is ignored. On the SKIP-th valid sample, go to ACCUM.
  - ACCUM: each valid_i adds sign-extended freq_i into the accumulator and increments the sample counter (0..DECIM-1). The accumulator is IN_W+LOG2_DECIM bits wide and cannot overflow.
  - ACCUM is never left except by reset.
- Dump: on the valid_i cycle where the sample counter equals DECIM-1:
  - result = (accumulator + freq_i) >>> LOG2_DECIM, an arithmetic shift that rounds toward minus infinity, truncated to IN_W bits (always in range);
  - the result is pushed into the FIFO at that clock edge;
  - the accumulator and counter clear to 0 at the same edge; the current sample is not carried into the next block.
- Latency: valid_o rises in the cycle after the clock edge that samples the DECIM-th valid input, provided the FIFO was empty.
- Gaps: valid_i low holds all state. Gaps of any length inside a block are allowed.
- FIFO: 2 entries, first-in first-out. valid_o = not empty. freq_o = head entry, driven from a register with no combinational path from freq_i.
- Push and pop in the same cycle:
  - FIFO not full: both occur; occupancy is unchanged if there was one entry.
  - FIFO full: the pop frees the slot, the push is accepted, and there is no overflow.
- Overflow: a push with the FIFO full and no pop that cycle drops the new result and leaves the FIFO contents unchanged. overflow_o goes to 1 at that edge and stays 1 until rst.
- ready_i while valid_o is low has no effect.
- Reset mid-block: the partial accumulation is discarded and the FIFO is flushed. The skip phase restarts, because the upstream phase history is invalid after a reset.

Test Plan:
- Skip and average: DECIM=4, SKIP=2, ready_i=1. Drive 9999, 9999, 100, 200, 300, 400 on consecutive cycles. Required: exactly one output, freq_o=250, with valid_o high in the cycle after 400 is sampled. The 9999 samples have no effect.
- Negative rounding: DECIM=4, SKIP=0. Drive -1, -1, -1, -2 (sum -5). Required: freq_o=-2. Then drive -32768 four times. Required: freq_o=-32768, with no wrap.
- Gapped input: DECIM=8, SKIP=0. Drive eight samples of 1000, with valid_i low for 3 random cycles between each pair. Required: one output of 1000, and nothing emitted early.
- Backpressure and overflow: DECIM=2, SKIP=0, ready_i=0. Drive pairs (10,30), (50,70), (90,110). Required: the FIFO holds 20 and 60, and overflow_o goes to 1 on the third dump. Then raise ready_i. Required: 20 then 60 on consecutive cycles, then valid_o=0; overflow_o remains 1.
- Simultaneous push/pop when full: DECIM=2, FIFO holding 20 and 60. Assert ready_i on the same cycle the (100,200) dump occurs. Required: 20 is popped, 150 is accepted, overflow_o stays 0, and the next outputs are 60 then 150.
- Reset mid-operation: DECIM=4, SKIP=1. Drive 5, 100, 100, then assert rst for one cycle. Then drive 7, 40, 40, 40, 40. Required: during and after reset valid_o=0, overflow_o=0, and the FIFO is empty; the first output after reset is 40.

Source files
------------

// File: rtl/fm_freq_decimator.sv
// fm_freq_decimator: drops the first SKIP valid frequency samples after reset,
// boxcar-averages each following block of DECIM samples, and queues the
// results in a 2-entry FIFO toward the audio back end.
//   clk, rst            : clock, synchronous active-high reset
//   freq_i, valid_i     : signed instantaneous-frequency input stream
//   freq_o, valid_o     : FIFO head (registered), FIFO non-empty
//   ready_i             : downstream pop when valid_o is high
//   overflow_o          : sticky, a result was dropped on a full FIFO
module fm_freq_decimator #(
  parameter int DECIM      = 8,
  parameter int LOG2_DECIM = 3,
  parameter int SKIP       = 2,
  parameter int IN_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] freq_i,
  input  logic            valid_i,
  output logic [IN_W-1:0] freq_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            overflow_o
);

  localparam int ACC_W  = IN_W + LOG2_DECIM;
  localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic {
    S_SKIP,
    S_ACCUM
  } state_t;

  localparam state_t RESET_STATE = (SKIP == 0) ? S_ACCUM : S_SKIP;

  state_t                state_q, state_d;
  logic [SKIP_W-1:0]     skip_q, skip_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]       head_q, head_d;
  logic [IN_W-1:0]       tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_W-1:0]      freq_ext;
  logic [ACC_W-1:0]      sum;
  logic [IN_W-1:0]       result;
  logic                  push;
  logic                  pop;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    freq_ext = {{LOG2_DECIM{freq_i[IN_W-1]}}, freq_i};
    sum      = acc_q + freq_ext;
    // Dropping the low LOG2_DECIM bits is the arithmetic shift (floor);
    // the average of IN_W-bit samples always fits back in IN_W bits.
    result   = sum[ACC_W-1:LOG2_DECIM];

    unique case (state_q)
      S_SKIP: begin
        if (valid_i) begin
          skip_d = skip_q + 1'b1;
          if (skip_q == SKIP_LAST) begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (valid_i) begin
          if (cnt_q == '1) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // FIFO kept as head/tail registers so freq_o is always a flop output.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pop     = (count_q != 2'd0) && ready_i;

    unique case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = result;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = result;
        end else if (push) begin
          tail_d  = result;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = result;
          end else begin
            count_d = 2'd1;
          end
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      skip_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign freq_o     = head_q;
  assign valid_o    = (count_q != 2'd0);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fm_freq_decimator.sv
module tb_fm_freq_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] freq_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;

  logic [15:0] fo_a, fo_b, fo_c, fo_d, fo_e;
  logic        vo_a, vo_b, vo_c, vo_d, vo_e;
  logic        ov_a, ov_b, ov_c, ov_d, ov_e;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // A: DECIM4 SKIP2, B: DECIM4 SKIP0, C: DECIM8 SKIP0, D: DECIM2 SKIP0, E: DECIM4 SKIP1
  fm_freq_decimator #(.DECIM(4), .LOG2_DECIM(2), .SKIP(2), .IN_W(16)) u_a (
    .clk(clk), .rst(rst), .freq_i(freq_i), .valid_i(valid_i),
    .freq_o(fo_a), .valid_o(vo_a), .ready_i(ready_i), .overflow_o(ov_a));
  fm_freq_decimator #(.DECIM(4), .LOG2_DECIM(2), .SKIP(0), .IN_W(16)) u_b (
    .clk(clk), .rst(rst), .freq_i(freq_i), .valid_i(valid_i),
    .freq_o(fo_b), .valid_o(vo_b), .ready_i(ready_i), .overflow_o(ov_b));
  fm_freq_decimator #(.DECIM(8), .LOG2_DECIM(3), .SKIP(0), .IN_W(16)) u_c (
    .clk(clk), .rst(rst), .freq_i(freq_i), .valid_i(valid_i),
    .freq_o(fo_c), .valid_o(vo_c), .ready_i(ready_i), .overflow_o(ov_c));
  fm_freq_decimator #(.DECIM(2), .LOG2_DECIM(1), .SKIP(0), .IN_W(16)) u_d (
    .clk(clk), .rst(rst), .freq_i(freq_i), .valid_i(valid_i),
    .freq_o(fo_d), .valid_o(vo_d), .ready_i(ready_i), .overflow_o(ov_d));
  fm_freq_decimator #(.DECIM(4), .LOG2_DECIM(2), .SKIP(1), .IN_W(16)) u_e (
    .clk(clk), .rst(rst), .freq_i(freq_i), .valid_i(valid_i),
    .freq_o(fo_e), .valid_o(vo_e), .ready_i(ready_i), .overflow_o(ov_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [15:0] v);
    valid_i = 1'b1;
    freq_i  = v;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] vo_all;
    logic [4:0] ov_all;
    ready_i = 1'b0;
    do_reset();
    vo_all = {vo_a, vo_b, vo_c, vo_d, vo_e};
    ov_all = {ov_a, ov_b, ov_c, ov_d, ov_e};
    checks++;
    if (vo_all !== 5'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=00000", vo_all);
    end
    checks++;
    if (ov_all !== 5'b0) begin
      failures++;
      $display("FAIL reset_overflow got=%b exp=00000", ov_all);
    end
    checks++;
    if (fo_a !== 16'd0 || fo_d !== 16'd0) begin
      failures++;
      $display("FAIL reset_freq got=%0d/%0d exp=0/0", fo_a, fo_d);
    end
  endtask

  task automatic test_skip_average();
    logic [15:0] vec [6];
    vec = '{16'd9999, 16'd9999, 16'd100, 16'd200, 16'd300, 16'd400};
    ready_i = 1'b1;
    do_reset();
    for (int unsigned i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      freq_i  = vec[i];
      tick();
      if (i < 5) begin
        checks++;
        if (vo_a !== 1'b0) begin
          failures++;
          $display("FAIL skip_early_valid idx=%0d got=%b exp=0", i, vo_a);
        end
      end
    end
    valid_i = 1'b0;
    checks++;
    if (vo_a !== 1'b1 || fo_a !== 16'd250) begin
      failures++;
      $display("FAIL skip_avg got v=%b f=%0d exp v=1 f=250", vo_a, $signed(fo_a));
    end
    tick();
    checks++;
    if (vo_a !== 1'b0) begin
      failures++;
      $display("FAIL skip_single_output got v=%b exp v=0", vo_a);
    end
  endtask

  task automatic test_negative_rounding();
    ready_i = 1'b1;
    do_reset();
    drive(16'hFFFF);
    drive(16'hFFFF);
    drive(16'hFFFF);
    drive(16'hFFFE);
    checks++;
    if (vo_b !== 1'b1 || fo_b !== 16'hFFFE) begin
      failures++;
      $display("FAIL neg_round got v=%b f=%0d exp v=1 f=-2", vo_b, $signed(fo_b));
    end
    for (int unsigned i = 0; i < 4; i++) drive(16'h8000);
    checks++;
    if (vo_b !== 1'b1 || fo_b !== 16'h8000) begin
      failures++;
      $display("FAIL neg_full_scale got v=%b f=%0d exp v=1 f=-32768", vo_b, $signed(fo_b));
    end
  endtask

  task automatic test_gapped();
    ready_i = 1'b1;
    do_reset();
    for (int unsigned i = 0; i < 8; i++) begin
      drive(16'd1000);
      if (i < 7) begin
        checks++;
        if (vo_c !== 1'b0) begin
          failures++;
          $display("FAIL gap_early idx=%0d got v=%b exp v=0", i, vo_c);
        end
        for (int unsigned g = 0; g < 3; g++) begin
          freq_i = 16'($urandom);
          tick();
        end
      end
    end
    checks++;
    if (vo_c !== 1'b1 || fo_c !== 16'd1000) begin
      failures++;
      $display("FAIL gap_avg got v=%b f=%0d exp v=1 f=1000", vo_c, $signed(fo_c));
    end
  endtask

  task automatic test_overflow();
    ready_i = 1'b0;
    do_reset();
    drive(16'd10); drive(16'd30);
    drive(16'd50); drive(16'd70);
    checks++;
    if (vo_d !== 1'b1 || fo_d !== 16'd20 || ov_d !== 1'b0) begin
      failures++;
      $display("FAIL ovf_fill got v=%b f=%0d o=%b exp v=1 f=20 o=0", vo_d, fo_d, ov_d);
    end
    drive(16'd90); drive(16'd110);
    checks++;
    if (ov_d !== 1'b1 || fo_d !== 16'd20) begin
      failures++;
      $display("FAIL ovf_flag got o=%b f=%0d exp o=1 f=20", ov_d, fo_d);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (vo_d !== 1'b1 || fo_d !== 16'd60) begin
      failures++;
      $display("FAIL ovf_drain2 got v=%b f=%0d exp v=1 f=60", vo_d, fo_d);
    end
    tick();
    checks++;
    if (vo_d !== 1'b0 || ov_d !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty got v=%b o=%b exp v=0 o=1", vo_d, ov_d);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    do_reset();
    drive(16'd10); drive(16'd30);
    drive(16'd50); drive(16'd70);
    drive(16'd100);
    ready_i = 1'b1;
    drive(16'd200);
    ready_i = 1'b0;
    checks++;
    if (vo_d !== 1'b1 || fo_d !== 16'd60 || ov_d !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pushpop got v=%b f=%0d o=%b exp v=1 f=60 o=0", vo_d, fo_d, ov_d);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (vo_d !== 1'b1 || fo_d !== 16'd150) begin
      failures++;
      $display("FAIL b2b_next got v=%b f=%0d exp v=1 f=150", vo_d, fo_d);
    end
    tick();
    checks++;
    if (vo_d !== 1'b0 || ov_d !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got v=%b o=%b exp v=0 o=0", vo_d, ov_d);
    end
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b1;
    do_reset();
    drive(16'd5); drive(16'd100); drive(16'd100);
    rst = 1'b1;
    tick();
    checks++;
    if (vo_e !== 1'b0 || ov_e !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_state got v=%b o=%b exp v=0 o=0", vo_e, ov_e);
    end
    rst = 1'b0;
    drive(16'd7);
    drive(16'd40); drive(16'd40); drive(16'd40);
    checks++;
    if (vo_e !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_early got v=%b exp v=0", vo_e);
    end
    drive(16'd40);
    checks++;
    if (vo_e !== 1'b1 || fo_e !== 16'd40) begin
      failures++;
      $display("FAIL mid_rst_avg got v=%b f=%0d exp v=1 f=40", vo_e, $signed(fo_e));
    end
  endtask

  initial begin
    test_reset();
    test_skip_average();
    test_negative_rounding();
    test_gapped();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
